// File: rtl/spike_window_counter.sv
// Counts spike events across N_LANES lanes over one tick-delimited window and
// latches the saturating window total, saturation flag and window length on each tick.
module spike_window_counter #(
    parameter int unsigned N_LANES   = 16,
    parameter int unsigned EDGE_MODE = 1,
    parameter logic [31:0] MAX_CNT   = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_LANES-1:0] spike_in,
    input  logic               tick,
    output logic [31:0]        spike_cnt_out,
    output logic               cnt_valid,
    output logic               sat_out,
    output logic [31:0]        window_cycles_out
);

    localparam int unsigned INC_W = $clog2(N_LANES + 1);

    logic [N_LANES-1:0] prev_spk;
    logic [N_LANES-1:0] ev;
    logic [INC_W-1:0]   inc;
    logic [31:0]        acc;
    logic               sat_acc;
    logic [31:0]        win_cyc;
    logic [32:0]        sum;
    logic [31:0]        sum_sat;
    logic               sat_now;
    logic [31:0]        win_cyc_next;

    always_comb begin
        ev = (EDGE_MODE != 0) ? (spike_in & ~prev_spk) : spike_in;
        inc = '0;
        if (enable) begin
            for (int unsigned i = 0; i < N_LANES; i++) begin
                inc = inc + INC_W'(ev[i]);
            end
        end
    end

    // 33-bit sum so an overflow past MAX_CNT is detected rather than wrapped
    always_comb begin
        sum     = {1'b0, acc} + 33'(inc);
        sat_now = (sum > {1'b0, MAX_CNT});
        sum_sat = sat_now ? MAX_CNT : sum[31:0];
        win_cyc_next = (win_cyc == '1) ? win_cyc : win_cyc + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_spk <= '0;
        end else begin
            prev_spk <= spike_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc               <= '0;
            sat_acc           <= 1'b0;
            win_cyc           <= '0;
            spike_cnt_out     <= '0;
            cnt_valid         <= 1'b0;
            sat_out           <= 1'b0;
            window_cycles_out <= '0;
        end else if (tick) begin
            spike_cnt_out     <= sum_sat;
            sat_out           <= sat_acc | sat_now;
            window_cycles_out <= win_cyc_next;
            cnt_valid         <= 1'b1;
            acc               <= '0;
            sat_acc           <= 1'b0;
            win_cyc           <= '0;
        end else begin
            acc       <= sum_sat;
            sat_acc   <= sat_acc | sat_now;
            win_cyc   <= win_cyc_next;
            cnt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_window_counter.sv
// Directed bench: three spike_window_counter instances (edge mode, level mode,
// level mode with MAX_CNT=20) share stimulus and are checked against hand-computed values.
module tb_spike_window_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] spike_in;
    logic        tick;

    logic [31:0] e_cnt, l_cnt, s_cnt;
    logic        e_vld, l_vld, s_vld;
    logic        e_sat, l_sat, s_sat;
    logic [31:0] e_win, l_win, s_win;

    int checks;
    int errors;

    spike_window_counter #(.N_LANES(16), .EDGE_MODE(1)) u_edge (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .tick(tick),
        .spike_cnt_out(e_cnt), .cnt_valid(e_vld), .sat_out(e_sat), .window_cycles_out(e_win)
    );

    spike_window_counter #(.N_LANES(16), .EDGE_MODE(0)) u_lvl (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .tick(tick),
        .spike_cnt_out(l_cnt), .cnt_valid(l_vld), .sat_out(l_sat), .window_cycles_out(l_win)
    );

    spike_window_counter #(.N_LANES(16), .EDGE_MODE(0), .MAX_CNT(32'd20)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in), .tick(tick),
        .spike_cnt_out(s_cnt), .cnt_valid(s_vld), .sat_out(s_sat), .window_cycles_out(s_win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: apply inputs, let the edge happen, settle 1 time unit after it.
    task automatic cyc(input logic t, input logic en, input logic [15:0] spk);
        tick = t; enable = en; spike_in = spk;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        tick = 1'b0; enable = 1'b1; spike_in = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; enable = 1'b1; spike_in = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (l_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", l_cnt); end
        checks++; if (l_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", l_vld); end
        checks++; if (s_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b exp 0", s_sat); end
        checks++; if (e_win !== 32'd0) begin errors++; $display("FAIL reset_win got %0d exp 0", e_win); end
        #1 reset = 1'b0;
    endtask

    task automatic test_edge_basic();
        do_reset();
        for (int c = 1; c <= 9; c++) cyc(1'b0, 1'b1, (c <= 5) ? 16'h0008 : 16'h0000);
        checks++; if (e_vld !== 1'b0) begin errors++; $display("FAIL edge_pre_vld got %0b exp 0", e_vld); end
        cyc(1'b1, 1'b1, 16'h0000);
        checks++; if (e_cnt !== 32'd1) begin errors++; $display("FAIL edge_cnt got %0d exp 1", e_cnt); end
        checks++; if (e_vld !== 1'b1) begin errors++; $display("FAIL edge_vld got %0b exp 1", e_vld); end
        checks++; if (e_win !== 32'd10) begin errors++; $display("FAIL edge_win got %0d exp 10", e_win); end
        checks++; if (e_sat !== 1'b0) begin errors++; $display("FAIL edge_sat got %0b exp 0", e_sat); end
        checks++; if (l_cnt !== 32'd5) begin errors++; $display("FAIL edge_lvl_cnt got %0d exp 5", l_cnt); end
        cyc(1'b0, 1'b1, 16'h0000);
        checks++; if (e_vld !== 1'b0) begin errors++; $display("FAIL edge_post_vld got %0b exp 0", e_vld); end
        checks++; if (e_cnt !== 32'd1) begin errors++; $display("FAIL edge_hold_cnt got %0d exp 1", e_cnt); end
    endtask

    task automatic test_level_mode();
        do_reset();
        repeat (4) cyc(1'b0, 1'b1, 16'hFFFF);
        cyc(1'b1, 1'b1, 16'h000F);
        checks++; if (l_cnt !== 32'd68) begin errors++; $display("FAIL lvl_cnt got %0d exp 68", l_cnt); end
        checks++; if (l_win !== 32'd5) begin errors++; $display("FAIL lvl_win got %0d exp 5", l_win); end
        checks++; if (e_cnt !== 32'd16) begin errors++; $display("FAIL lvl_edge_cnt got %0d exp 16", e_cnt); end
        checks++; if (s_cnt !== 32'd20) begin errors++; $display("FAIL lvl_sat_cnt got %0d exp 20", s_cnt); end
        checks++; if (s_sat !== 1'b1) begin errors++; $display("FAIL lvl_sat_flag got %0b exp 1", s_sat); end
        checks++; if (l_sat !== 1'b0) begin errors++; $display("FAIL lvl_nosat got %0b exp 0", l_sat); end
    endtask

    task automatic test_enable();
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, !(i == 4 || i == 5), 16'h0001 << i);
        cyc(1'b1, 1'b1, 16'h0000);
        checks++; if (e_cnt !== 32'd6) begin errors++; $display("FAIL en_edge_cnt got %0d exp 6", e_cnt); end
        checks++; if (l_cnt !== 32'd6) begin errors++; $display("FAIL en_lvl_cnt got %0d exp 6", l_cnt); end
        checks++; if (e_win !== 32'd9) begin errors++; $display("FAIL en_win got %0d exp 9", e_win); end
        cyc(1'b0, 1'b0, 16'h0004);
        repeat (3) cyc(1'b0, 1'b1, 16'h0004);
        cyc(1'b1, 1'b1, 16'h0004);
        checks++; if (e_cnt !== 32'd0) begin errors++; $display("FAIL held_edge_cnt got %0d exp 0", e_cnt); end
        checks++; if (l_cnt !== 32'd4) begin errors++; $display("FAIL held_lvl_cnt got %0d exp 4", l_cnt); end
        checks++; if (e_win !== 32'd5) begin errors++; $display("FAIL held_win got %0d exp 5", e_win); end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (2) cyc(1'b0, 1'b1, 16'hFFFF);
        cyc(1'b1, 1'b1, 16'h0000);
        checks++; if (s_cnt !== 32'd20) begin errors++; $display("FAIL sat_cnt got %0d exp 20", s_cnt); end
        checks++; if (s_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %0b exp 1", s_sat); end
        checks++; if (l_cnt !== 32'd32) begin errors++; $display("FAIL sat_lvl_cnt got %0d exp 32", l_cnt); end
        repeat (3) cyc(1'b0, 1'b1, 16'h0001);
        cyc(1'b1, 1'b1, 16'h0000);
        checks++; if (s_cnt !== 32'd3) begin errors++; $display("FAIL sat_next_cnt got %0d exp 3", s_cnt); end
        checks++; if (s_sat !== 1'b0) begin errors++; $display("FAIL sat_next_flag got %0b exp 0", s_sat); end
        checks++; if (e_cnt !== 32'd1) begin errors++; $display("FAIL sat_next_edge got %0d exp 1", e_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 16'h0001);
            checks++; if (l_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d] got %0b exp 1", k, l_vld); end
            checks++; if (l_cnt !== 32'd1) begin errors++; $display("FAIL b2b_cnt[%0d] got %0d exp 1", k, l_cnt); end
            checks++; if (l_win !== 32'd1) begin errors++; $display("FAIL b2b_win[%0d] got %0d exp 1", k, l_win); end
            checks++; if (e_cnt !== ((k == 0) ? 32'd1 : 32'd0)) begin
                errors++; $display("FAIL b2b_edge[%0d] got %0d exp %0d", k, e_cnt, (k == 0) ? 1 : 0);
            end
        end
        cyc(1'b0, 1'b1, 16'h0000);
        checks++; if (l_vld !== 1'b0) begin errors++; $display("FAIL b2b_end_vld got %0b exp 0", l_vld); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cyc(1'b0, 1'b1, 16'h001F);
        cyc(1'b1, 1'b1, 16'h0000);
        checks++; if (l_cnt !== 32'd5) begin errors++; $display("FAIL mr_pre_cnt got %0d exp 5", l_cnt); end
        cyc(1'b0, 1'b1, 16'h007F);
        #2 reset = 1'b1;
        #1;
        checks++; if (l_cnt !== 32'd0) begin errors++; $display("FAIL mr_async_cnt got %0d exp 0", l_cnt); end
        checks++; if (l_win !== 32'd0) begin errors++; $display("FAIL mr_async_win got %0d exp 0", l_win); end
        tick = 1'b1; spike_in = 16'hFFFF;
        @(posedge clk); #1;
        checks++; if (l_vld !== 1'b0) begin errors++; $display("FAIL mr_hold_vld got %0b exp 0", l_vld); end
        checks++; if (s_sat !== 1'b0) begin errors++; $display("FAIL mr_hold_sat got %0b exp 0", s_sat); end
        checks++; if (e_cnt !== 32'd0) begin errors++; $display("FAIL mr_hold_cnt got %0d exp 0", e_cnt); end
        tick = 1'b0; spike_in = '0;
        reset = 1'b0;
        cyc(1'b0, 1'b1, 16'h0003);
        checks++; if (l_vld !== 1'b0) begin errors++; $display("FAIL mr_novld got %0b exp 0", l_vld); end
        cyc(1'b1, 1'b1, 16'h0000);
        checks++; if (l_cnt !== 32'd2) begin errors++; $display("FAIL mr_cnt got %0d exp 2", l_cnt); end
        checks++; if (e_cnt !== 32'd2) begin errors++; $display("FAIL mr_edge_cnt got %0d exp 2", e_cnt); end
        checks++; if (l_win !== 32'd2) begin errors++; $display("FAIL mr_win got %0d exp 2", l_win); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; tick = 1'b0; enable = 1'b0; spike_in = '0;
        test_reset();
        test_edge_basic();
        test_level_mode();
        test_enable();
        test_saturation();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
